// File: rtl/dl_rx_pack.sv
// dl_rx_pack: pairs corrected nibbles from the SECDED checker into bytes and buffers them in a FIFO.
// Optional error counters are built when DL_RX_ERR_CNT_EN is defined; otherwise they read as zero.
module dl_rx_pack #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_data,
    input  logic                     in_err_detect,
    input  logic                     in_err_multpl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_pulse,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         corr_cnt,
    output logic [CNT_W-1:0]         uncorr_cnt
);

    // state | meaning
    // LO    | waiting for the low nibble of a byte
    // HI    | low nibble held, waiting for the high nibble
    localparam logic [0:0] ST_LO = 1'b0;
    localparam logic [0:0] ST_HI = 1'b1;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [0:0]    r_state;
    logic [3:0]    r_lo;
    logic          r_bad;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_err_pulse;

    logic w_accept;
    logic w_hi_accept;
    logic w_drop;
    logic w_push;
    logic w_pop;

    assign in_ready    = (r_state == ST_LO) || (r_count != FULL_CNT);
    assign w_accept    = in_valid && in_ready;
    assign w_hi_accept = w_accept && (r_state == ST_HI);
    assign w_drop      = w_hi_accept && (r_bad || in_err_multpl);
    assign w_push      = w_hi_accept && !(r_bad || in_err_multpl);
    assign w_pop       = out_valid && out_ready;

    assign out_valid  = (r_count != '0);
    assign out_data   = r_mem[r_rptr];
    assign fifo_count = r_count;
    assign err_pulse  = r_err_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LO;
            r_lo        <= 4'h0;
            r_bad       <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_drop;
            if (w_accept) begin
                if (r_state == ST_LO) begin
                    r_lo    <= in_data;
                    r_bad   <= in_err_multpl;
                    r_state <= ST_HI;
                end else begin
                    r_state <= ST_LO;
                end
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {in_data, r_lo};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

`ifdef DL_RX_ERR_CNT_EN
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_uncorr_cnt;

    // Clear has priority over a same-cycle increment; both counters saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_accept) begin
            if (in_err_detect && !in_err_multpl && (r_corr_cnt != '1)) begin
                r_corr_cnt <= r_corr_cnt + 1'b1;
            end
            if (in_err_multpl && (r_uncorr_cnt != '1)) begin
                r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
            end
        end
    end

    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;
`else
    logic w_unused_cnt_in;

    assign w_unused_cnt_in = cnt_clr ^ in_err_detect;
    assign corr_cnt        = '0;
    assign uncorr_cnt      = '0;
`endif

endmodule

// File: tb/tb_dl_rx_pack.sv
// tb_dl_rx_pack: directed-vector bench for dl_rx_pack (DEPTH=4, CNT_W=2).
module tb_dl_rx_pack;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
`ifdef DL_RX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic             in_err_detect;
    logic             in_err_multpl;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [2:0]       fifo_count;
    logic             err_pulse;
    logic             cnt_clr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    dl_rx_pack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_err_detect (in_err_detect),
        .in_err_multpl (in_err_multpl),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .fifo_count    (fifo_count),
        .err_pulse     (err_pulse),
        .cnt_clr       (cnt_clr),
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    // Offers one nibble; returns #1 after the accepting edge.
    task automatic nib(input logic [3:0] d, input logic det, input logic mul);
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_data       = d;
        in_err_detect = det;
        in_err_multpl = mul;
        in_valid      = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        in_valid      = 1'b0;
        in_err_detect = 1'b0;
        in_err_multpl = 1'b0;
        check("nib_accept_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_data"},  {24'd0, out_data}, 32'h00);
        check({tag, "_count"},     {29'd0, fifo_count}, 32'd0);
        check({tag, "_err_pulse"}, {31'd0, err_pulse}, 32'd0);
        check({tag, "_corr"},      {30'd0, corr_cnt}, 32'd0);
        check({tag, "_uncorr"},    {30'd0, uncorr_cnt}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; in_err_detect = 1'b0;
        in_err_multpl = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // clean stream
        out_ready = 1'b1;
        nib(4'h3, 1'b0, 1'b0);
        check("clean_no_early_byte", {31'd0, out_valid}, 32'd0);
        nib(4'hA, 1'b0, 1'b0);
        check("clean_valid", {31'd0, out_valid}, 32'd1);
        check("clean_data", {24'd0, out_data}, 32'hA3);
        check("clean_count", {29'd0, fifo_count}, 32'd1);
        check("clean_corr", {30'd0, corr_cnt}, 32'd0);
        @(posedge clk); #1;
        check("clean_drained", {31'd0, out_valid}, 32'd0);

        // corrected single-bit nibble
        nib(4'h5, 1'b1, 1'b0);
        nib(4'h1, 1'b0, 1'b0);
        check("corr_data", {24'd0, out_data}, 32'h15);
        check("corr_valid", {31'd0, out_valid}, 32'd1);
        check("corr_cnt1", {30'd0, corr_cnt}, cexp(1));
        @(posedge clk); #1;

        // uncorrectable low nibble drops the pair
        nib(4'h7, 1'b0, 1'b1);
        nib(4'h2, 1'b0, 1'b0);
        check("drop_pulse", {31'd0, err_pulse}, 32'd1);
        check("drop_no_push", {31'd0, out_valid}, 32'd0);
        check("drop_uncorr", {30'd0, uncorr_cnt}, cexp(1));
        @(posedge clk); #1;
        check("drop_pulse_one_cycle", {31'd0, err_pulse}, 32'd0);
        nib(4'h4, 1'b0, 1'b0);
        nib(4'h8, 1'b0, 1'b0);
        check("after_drop_data", {24'd0, out_data}, 32'h84);
        check("after_drop_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;

        // backpressure: 2*DEPTH+1 nibbles with the consumer stalled
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) nib(4'(i), 1'b0, 1'b0);
        check("bp_full", {29'd0, fifo_count}, 32'd4);
        check("bp_stall", {31'd0, in_ready}, 32'd0);
        check("bp_head", {24'd0, out_data}, 32'h21);
        @(negedge clk);
        in_data = 4'hA; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_d1", {24'd0, out_data}, 32'h43);
        check("bp_cnt1", {29'd0, fifo_count}, 32'd3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_d2", {24'd0, out_data}, 32'h65);
        check("bp_cnt2", {29'd0, fifo_count}, 32'd3);
        @(posedge clk); #1;
        check("bp_d3", {24'd0, out_data}, 32'h87);
        @(posedge clk); #1;
        check("bp_d4", {24'd0, out_data}, 32'hA9);
        check("bp_cnt4", {29'd0, fifo_count}, 32'd1);
        @(posedge clk); #1;
        check("bp_empty", {31'd0, out_valid}, 32'd0);
        check("bp_ctr_stable", {30'd0, corr_cnt}, cexp(1));

        // saturation then clear racing an increment
        for (int i = 0; i < 5; i++) nib(4'h6, 1'b1, 1'b0);
        check("sat_corr", {30'd0, corr_cnt}, cexp(3));
        cnt_clr = 1'b1;
        nib(4'h6, 1'b1, 1'b0);
        cnt_clr = 1'b0;
        check("clr_corr", {30'd0, corr_cnt}, 32'd0);
        check("clr_uncorr", {30'd0, uncorr_cnt}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sat_drained", {31'd0, out_valid}, 32'd0);

        // reset in the middle of a pair with a byte buffered
        out_ready = 1'b0;
        nib(4'hB, 1'b0, 1'b0);
        nib(4'hC, 1'b0, 1'b0);
        nib(4'hF, 1'b0, 1'b0);
        check("mid_count", {29'd0, fifo_count}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        nib(4'h1, 1'b0, 1'b0);
        check("midrst_no_pulse", {31'd0, err_pulse}, 32'd0);
        nib(4'h2, 1'b0, 1'b0);
        check("midrst_data", {24'd0, out_data}, 32'h21);
        check("midrst_valid", {31'd0, out_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
